// File: rtl/maze_turn_sequencer.sv
// Game-flow and move sequencer for the two-player maze game.
// Player 1 runs the maze, then player 2, then the winner is reported.
// Each accepted direction request becomes one probe of the shared
// wall/goal lookup unit, followed by a commit cycle that applies the move.
module maze_turn_sequencer #(
    parameter int STEP    = 16,
    parameter int START_X = 80,
    parameter int START_Y = 32,
    parameter int MAX_X   = 639,
    parameter int MAX_Y   = 479
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       tick,
    input  logic [3:0] btn,
    output logic       probe_req,
    output logic [9:0] probe_x,
    output logic [9:0] probe_y,
    input  logic       probe_ack,
    input  logic       probe_wall,
    input  logic       probe_goal,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic [9:0] steps,
    output logic [9:0] p1_steps,
    output logic [9:0] p2_steps,
    output logic [1:0] state,
    output logic [1:0] winner
);

    typedef enum logic [1:0] {
        QI      = 2'b00,
        QGAME_1 = 2'b01,
        QGAME_2 = 2'b10,
        QDONE   = 2'b11
    } game_t;

    typedef enum logic [1:0] {
        M_IDLE   = 2'b00,
        M_PROBE  = 2'b01,
        M_COMMIT = 2'b10
    } move_t;

    localparam logic [9:0]  STEP_V  = 10'(STEP);
    localparam logic [9:0]  START_XV = 10'(START_X);
    localparam logic [9:0]  START_YV = 10'(START_Y);
    localparam logic [10:0] MAX_XV  = 11'(MAX_X);
    localparam logic [10:0] MAX_YV  = 11'(MAX_Y);

    // Step counter increment that sticks at the 10-bit ceiling.
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == 10'd1023) ? v : v + 10'd1;
    endfunction

    game_t      game_cur, game_nxt;
    move_t      move_cur, move_nxt;
    logic [9:0] tgt_x, tgt_y;
    logic       oob;
    logic       single;
    logic       accept;
    logic       in_game;
    logic       commit_move;
    logic       wall_lat, goal_lat;
    logic [9:0] steps_inc;

    assign in_game     = (game_cur == QGAME_1) || (game_cur == QGAME_2);
    assign commit_move = in_game && (move_cur == M_COMMIT) && !wall_lat;
    assign steps_inc   = sat_inc(steps);
    assign probe_req   = in_game && (move_cur == M_PROBE);
    assign state       = game_cur;
    assign winner      = (game_cur != QDONE)      ? 2'b00 :
                         (p1_steps <= p2_steps)   ? 2'b01 : 2'b10;

    // Candidate cell for a single pressed button, plus the out-of-bounds flag.
    always_comb begin
        tgt_x  = pos_x;
        tgt_y  = pos_y;
        oob    = 1'b0;
        single = 1'b1;
        case (btn)
            4'b1000: begin
                tgt_y = pos_y - STEP_V;
                oob   = (pos_y < STEP_V);
            end
            4'b0100: begin
                tgt_x = pos_x - STEP_V;
                oob   = (pos_x < STEP_V);
            end
            4'b0010: begin
                tgt_y = pos_y + STEP_V;
                oob   = (({1'b0, pos_y} + {1'b0, STEP_V}) > MAX_YV);
            end
            4'b0001: begin
                tgt_x = pos_x + STEP_V;
                oob   = (({1'b0, pos_x} + {1'b0, STEP_V}) > MAX_XV);
            end
            default: single = 1'b0;
        endcase
    end

    // Next game state and move substate; moves only run while a player is active.
    always_comb begin
        game_nxt = game_cur;
        move_nxt = move_cur;
        accept   = 1'b0;
        case (game_cur)
            QI: begin
                move_nxt = M_IDLE;
                if (start) game_nxt = QGAME_1;
            end
            QGAME_1, QGAME_2: begin
                case (move_cur)
                    M_IDLE: begin
                        // Out-of-bounds targets count as walls: no probe, stay idle.
                        if (tick && single && !oob) begin
                            accept   = 1'b1;
                            move_nxt = M_PROBE;
                        end
                    end
                    M_PROBE: begin
                        if (probe_ack) move_nxt = M_COMMIT;
                    end
                    M_COMMIT: begin
                        move_nxt = M_IDLE;
                        if (!wall_lat && goal_lat)
                            game_nxt = (game_cur == QGAME_1) ? QGAME_2 : QDONE;
                    end
                    default: move_nxt = M_IDLE;
                endcase
            end
            default: move_nxt = M_IDLE;
        endcase
    end

    // Control state registers; reset abandons any outstanding probe.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            game_cur <= QI;
            move_cur <= M_IDLE;
        end else begin
            game_cur <= game_nxt;
            move_cur <= move_nxt;
        end
    end

    // Probe target and lookup result; the target doubles as the commit position.
    always_ff @(posedge clk) begin
        if (accept) begin
            probe_x <= tgt_x;
            probe_y <= tgt_y;
        end
        if ((move_cur == M_PROBE) && probe_ack) begin
            wall_lat <= probe_wall;
            goal_lat <= probe_goal;
        end
    end

    // Player position and step counters, updated on an open-cell commit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos_x    <= START_XV;
            pos_y    <= START_YV;
            steps    <= 10'd0;
            p1_steps <= 10'd0;
            p2_steps <= 10'd0;
        end else if (commit_move) begin
            if (goal_lat && (game_cur == QGAME_1)) begin
                // Player 1 done: record the score and hand the maze to player 2.
                p1_steps <= steps_inc;
                pos_x    <= START_XV;
                pos_y    <= START_YV;
                steps    <= 10'd0;
            end else begin
                pos_x <= probe_x;
                pos_y <= probe_y;
                steps <= steps_inc;
                if (goal_lat) p2_steps <= steps_inc;
            end
        end
    end

endmodule

// File: tb/tb_maze_turn_sequencer.sv
// Self-checking bench for maze_turn_sequencer: a move-level game model
// predicts every output each cycle, plus directed literal expectations.
module tb_maze_turn_sequencer;

    logic       clk = 1'b0;
    logic       reset_n, start, tick, probe_ack, probe_wall, probe_goal;
    logic [3:0] btn;
    logic       probe_req;
    logic [9:0] probe_x, probe_y, pos_x, pos_y, steps, p1_steps, p2_steps;
    logic [1:0] state, winner;

    always #5 clk = ~clk;

    maze_turn_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .tick(tick), .btn(btn),
        .probe_req(probe_req), .probe_x(probe_x), .probe_y(probe_y),
        .probe_ack(probe_ack), .probe_wall(probe_wall), .probe_goal(probe_goal),
        .pos_x(pos_x), .pos_y(pos_y), .steps(steps),
        .p1_steps(p1_steps), .p2_steps(p2_steps), .state(state), .winner(winner)
    );

    int checks = 0;
    int errors = 0;

    // Game model: what the outputs must be right now.
    int exp_state = 0, exp_px = 80, exp_py = 32, exp_steps = 0, exp_p1 = 0, exp_p2 = 0;
    int exp_tx = 0, exp_ty = 0;
    bit exp_req = 0;
    bit chk_on = 0;
    int seen_req, seen_py;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, want);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 1023) ? 1023 : v + 1;
    endfunction

    // Where a single-button request leads from the current position; 0 if not a move.
    function automatic bit plan(input logic [3:0] b, output int tx, output int ty);
        int dx;
        int dy;
        dx = 0;
        dy = 0;
        tx = exp_px;
        ty = exp_py;
        case (b)
            4'b1000: dy = -16;
            4'b0100: dx = -16;
            4'b0010: dy = 16;
            4'b0001: dx = 16;
            default: return 1'b0;
        endcase
        tx = exp_px + dx;
        ty = exp_py + dy;
        return (tx >= 0) && (tx <= 639) && (ty >= 0) && (ty <= 479);
    endfunction

    // One clock; applies reset and the idle-to-game rule to the model.
    task automatic step();
        bit rs;
        bit st;
        rs = reset_n;
        st = start;
        @(posedge clk);
        #1;
        if (!rs) begin
            exp_state = 0; exp_px = 80; exp_py = 32; exp_steps = 0;
            exp_p1 = 0; exp_p2 = 0; exp_req = 0;
        end else if (exp_state == 0 && st) begin
            exp_state = 1;
        end
        chk_on = 1;
    endtask

    // A tick with buttons b; if it becomes a probe, answer after dly cycles.
    task automatic move(input logic [3:0] b, input int dly, input bit w, input bit g);
        int gs;
        bit ok;
        int tx;
        int ty;
        gs = exp_state;
        ok = plan(b, tx, ty);
        tick = 1'b1;
        btn = b;
        step();
        tick = 1'b0;
        btn = 4'b0000;
        seen_req = int'(probe_req);
        seen_py = int'(probe_y);
        if (!((gs == 1) || (gs == 2)) || !ok) return;
        exp_req = 1;
        exp_tx = tx;
        exp_ty = ty;
        repeat (dly) begin
            tick = 1'($urandom);
            btn = 4'($urandom);
            probe_wall = 1'($urandom);
            probe_goal = 1'($urandom);
            step();
        end
        tick = 1'($urandom);
        btn = 4'($urandom);
        probe_ack = 1'b1;
        probe_wall = w;
        probe_goal = g;
        step();
        exp_req = 0;
        probe_ack = 1'b0;
        probe_wall = 1'($urandom);
        probe_goal = 1'($urandom);
        step();
        tick = 1'b0;
        btn = 4'b0000;
        if (!w) begin
            if (g && gs == 1) begin
                exp_p1 = sat(exp_steps);
                exp_steps = 0; exp_px = 80; exp_py = 32; exp_state = 2;
            end else begin
                exp_steps = sat(exp_steps);
                exp_px = tx;
                exp_py = ty;
                if (g) begin
                    exp_p2 = exp_steps;
                    exp_state = 3;
                end
            end
        end
    endtask

    // Idle cycles with stray lookup responses that must be ignored.
    task automatic idle(input int n);
        repeat (n) begin
            probe_ack = 1'($urandom);
            probe_wall = 1'($urandom);
            probe_goal = 1'($urandom);
            step();
        end
        probe_ack = 1'b0;
    endtask

    // Per-cycle comparison of every output against the game model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("state", int'(state), exp_state);
            chk("pos_x", int'(pos_x), exp_px);
            chk("pos_y", int'(pos_y), exp_py);
            chk("steps", int'(steps), exp_steps);
            chk("p1_steps", int'(p1_steps), exp_p1);
            chk("p2_steps", int'(p2_steps), exp_p2);
            chk("winner", int'(winner), (exp_state != 3) ? 0 : ((exp_p1 <= exp_p2) ? 1 : 2));
            chk("probe_req", int'(probe_req), int'(exp_req));
            if (exp_req) begin
                chk("probe_x", int'(probe_x), exp_tx);
                chk("probe_y", int'(probe_y), exp_ty);
            end
        end
    end

    initial begin
        int r;
        logic [3:0] b;
        reset_n = 1'b0; start = 1'b0; tick = 1'b0; btn = 4'b0000;
        probe_ack = 1'b0; probe_wall = 1'b0; probe_goal = 1'b0;
        step();
        step();
        chk("rst_state", int'(state), 0);
        chk("rst_pos_x", int'(pos_x), 80);
        chk("rst_req", int'(probe_req), 0);

        reset_n = 1'b1;
        start = 1'b1;
        step();
        chk("start_state", int'(state), 1);
        chk("start_pos_y", int'(pos_y), 32);
        chk("start_steps", int'(steps), 0);

        move(4'b0010, 1, 1'b0, 1'b0);
        chk("down_req", seen_req, 1);
        chk("down_probe_y", seen_py, 48);
        chk("down_pos_y", int'(pos_y), 48);
        chk("down_steps", int'(steps), 1);

        move(4'b0100, 0, 1'b1, 1'b0);
        chk("wall_pos_x", int'(pos_x), 80);
        chk("wall_steps", int'(steps), 1);

        move(4'b1010, 0, 1'b0, 1'b0);
        chk("multi_btn_req", seen_req, 0);

        repeat (5) move(4'b0100, 0, 1'b0, 1'b0);
        chk("left_edge_x", int'(pos_x), 0);
        move(4'b0100, 0, 1'b0, 1'b0);
        chk("oob_req", seen_req, 0);
        chk("oob_pos_x", int'(pos_x), 0);
        chk("oob_steps", int'(steps), 6);

        repeat (5) move(4'b0001, 1, 1'b0, 1'b0);
        move(4'b0010, 2, 1'b0, 1'b1);
        chk("p1_final", int'(p1_steps), 12);
        chk("p1_state", int'(state), 2);
        chk("p2_start_x", int'(pos_x), 80);
        chk("p2_start_y", int'(pos_y), 32);

        repeat (11) move(4'b0010, 0, 1'b0, 1'b0);
        move(4'b0010, 0, 1'b0, 1'b1);
        chk("p2_final", int'(p2_steps), 12);
        chk("done_state", int'(state), 3);
        chk("tie_winner", int'(winner), 1);
        start = 1'b0;
        move(4'b0010, 0, 1'b0, 1'b0);
        chk("done_req", seen_req, 0);
        idle(3);

        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        tick = 1'b1;
        btn = 4'b0001;
        step();
        tick = 1'b0;
        btn = 4'b0000;
        exp_req = 1; exp_tx = 96; exp_ty = 32;
        step();
        reset_n = 1'b0;
        step();
        chk("rst_probe_req", int'(probe_req), 0);
        chk("rst_probe_state", int'(state), 0);
        probe_ack = 1'b1; probe_wall = 1'b0; probe_goal = 1'b1;
        step();
        probe_ack = 1'b0;
        reset_n = 1'b1;
        step();
        chk("late_ack_state", int'(state), 0);
        chk("late_ack_pos_x", int'(pos_x), 80);
        move(4'b0010, 0, 1'b0, 1'b0);
        chk("qi_tick_req", seen_req, 0);

        repeat (6) begin
            reset_n = 1'b0;
            step();
            reset_n = 1'b1;
            start = 1'b1;
            step();
            start = 1'($urandom);
            for (int i = 0; i < 200 && exp_state != 3; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    idle($urandom_range(1, 3));
                end else if (r == 1) begin
                    start = 1'($urandom);
                    step();
                end else begin
                    if (r < 7) b = 4'(1 << $urandom_range(0, 3));
                    else b = 4'($urandom);
                    move(b, $urandom_range(0, 3), $urandom_range(0, 2) == 0,
                         $urandom_range(0, 9) == 0);
                end
            end
            move(4'($urandom), 1, 1'b0, 1'b1);
            idle(2);
        end

        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        start = 1'b1;
        step();
        for (int i = 0; i < 1030; i++)
            move((i % 2 == 0) ? 4'b0010 : 4'b1000, 0, 1'b0, 1'b0);
        chk("sat_steps", int'(steps), 1023);
        move(4'b0010, 0, 1'b0, 1'b1);
        chk("sat_p1", int'(p1_steps), 1023);
        move(4'b0001, 0, 1'b0, 1'b1);
        chk("p2_win_p2", int'(p2_steps), 1);
        chk("p2_winner", int'(winner), 2);
        idle(2);

        chk_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
